// File: rtl/lsu_mem_port.sv
// Load/store unit initiator for a byte-enabled, word-addressed data memory; splits word-crossing accesses.
// Optional `define LSU_MISALIGN_TRAP_EN: misaligned H/W accesses trap instead of splitting.
module lsu_mem_port #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              misalign_exc,
    output logic [3:0]        dm_w_en,
    output logic [ADDR_W-1:0] dm_address,
    output logic [31:0]       dm_write_data,
    input  logic [31:0]       dm_read_data
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [31:0]         r_resp_rdata;
    logic [3:0]          r_dm_w_en;
    logic [ADDR_W-1:0]   r_dm_address;
    logic [31:0]         r_dm_write_data;
    logic [1:0]          r_code;
    logic                r_sext;
    logic [1:0]          r_off;
    logic                r_split;
    logic                r_load;
    logic [3:0]          r_en_hi;
    logic [31:0]         r_wdata_hi;
    logic [31:0]         r_acc0;

    logic                w_valid_op;
    logic [2:0]          w_bytes;
    logic [7:0]          w_bmask;
    logic [7:0]          w_mask;
    logic [1:0]          w_off;
    logic [63:0]         w_wshift;
    logic                w_split;
    logic                w_wr;
    logic                w_unused_addr;

    // Funct3 011 and 11x are never valid; BU/HU are valid for loads only.
    assign w_valid_op = (req_funct3[1:0] != 2'b11) &&
                        !(req_funct3[2] && (req_store || req_funct3[1:0] == 2'b10));
    assign w_off      = req_addr[1:0];
    assign w_bytes    = (req_funct3[1:0] == 2'b00) ? 3'd1 :
                        (req_funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;
    assign w_bmask    = (req_funct3[1:0] == 2'b00) ? 8'h01 :
                        (req_funct3[1:0] == 2'b01) ? 8'h03 : 8'h0F;
    assign w_mask     = w_bmask << w_off;
    assign w_wshift   = {32'h0, req_wdata} << {w_off, 3'b000};
    assign w_split    = w_valid_op && (({1'b0, w_off} + w_bytes) > 3'd4);
    assign w_wr       = req_store && w_valid_op;
    assign w_unused_addr = ^req_addr[31:ADDR_W];

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign dm_w_en       = r_dm_w_en;
    assign dm_address    = r_dm_address;
    assign dm_write_data = r_dm_write_data;

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign;
    assign w_misaligned = w_valid_op &&
                          ((w_bytes == 3'd2 && w_off[0]) || (w_bytes == 3'd4 && w_off != 2'b00));
    assign misalign_exc = r_misalign;
`else
    assign misalign_exc = 1'b0;
`endif

    // The merged {high, low} pair is shifted down by the byte offset, then sized and extended.
    function automatic logic [31:0] extract(input logic [63:0] v, input logic [1:0] off,
                                            input logic [1:0] code, input logic sext);
        logic [31:0] w;
        w = 32'(v >> {off, 3'b000});
        case (code)
            2'b00:   extract = {{24{sext & w[7]}}, w[7:0]};
            2'b01:   extract = {{16{sext & w[15]}}, w[15:0]};
            default: extract = w;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_req_ready     <= 1'b1;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= 32'h0;
            r_dm_w_en       <= 4'b0000;
            r_dm_address    <= '0;
            r_dm_write_data <= 32'h0;
            r_code          <= 2'b00;
            r_sext          <= 1'b0;
            r_off           <= 2'b00;
            r_split         <= 1'b0;
            r_load          <= 1'b0;
            r_en_hi         <= 4'b0000;
            r_wdata_hi      <= 32'h0;
            r_acc0          <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_misalign      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (w_misaligned) begin
                            r_state      <= DONE;
                            r_resp_valid <= 1'b1;
                            r_misalign   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                        end else begin
`endif
                            r_state         <= ACC0;
                            r_dm_address    <= {req_addr[ADDR_W-1:2], 2'b00};
                            r_dm_w_en       <= w_wr ? w_mask[3:0] : 4'b0000;
                            r_dm_write_data <= w_wshift[31:0];
                            r_en_hi         <= w_wr ? w_mask[7:4] : 4'b0000;
                            r_wdata_hi      <= w_wshift[63:32];
                            r_code          <= req_funct3[1:0];
                            r_sext          <= ~req_funct3[2];
                            r_off           <= w_off;
                            r_split         <= w_split;
                            r_load          <= !req_store && w_valid_op;
`ifdef LSU_MISALIGN_TRAP_EN
                        end
`endif
                    end
                end
                ACC0: begin
                    r_acc0 <= dm_read_data;
                    if (r_split) begin
                        r_state         <= ACC1;
                        r_dm_address    <= r_dm_address + ADDR_W'(4);
                        r_dm_w_en       <= r_en_hi;
                        r_dm_write_data <= r_wdata_hi;
                    end else begin
                        r_state      <= DONE;
                        r_dm_w_en    <= 4'b0000;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_load ? extract({32'h0, dm_read_data}, r_off, r_code, r_sext)
                                               : 32'h0;
                    end
                end
                ACC1: begin
                    r_state      <= DONE;
                    r_dm_w_en    <= 4'b0000;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= r_load ? extract({dm_read_data, r_acc0}, r_off, r_code, r_sext)
                                           : 32'h0;
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    r_misalign   <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: behavioural byte-enabled DM, vector table and scoreboard.
// Follows `define LSU_MISALIGN_TRAP_EN to select trap or split expectations.
module tb_lsu_mem_port;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              misalign_exc;
    logic [3:0]        dm_w_en;
    logic [ADDR_W-1:0] dm_address;
    logic [31:0]       dm_write_data;
    logic [31:0]       dm_read_data;

    always #5 clk = ~clk;

    lsu_mem_port #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign_exc(misalign_exc),
        .dm_w_en(dm_w_en), .dm_address(dm_address), .dm_write_data(dm_write_data),
        .dm_read_data(dm_read_data)
    );

    // Data memory: combinational read, byte-enabled write at the clock edge.
    logic [31:0] mem [0:(1<<(ADDR_W-2))-1];
    assign dm_read_data = mem[dm_address[ADDR_W-1:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (dm_w_en[b]) mem[dm_address[ADDR_W-1:2]][8*b +: 8] <= dm_write_data[8*b +: 8];
    end

    typedef struct { logic [31:0] rdata; logic exc; } exp_t;
    typedef struct {
        logic store; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
        logic [31:0] expRdata; int expLat;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];
    int   nCompared = 0;
    int   nMismatched = 0;
    int   cyc = 0;
    int   acceptCyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Every response is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1 && resp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected_resp: got resp_valid=1, expected no response");
            end else begin
                e = sbq.pop_front();
                checkOutput("resp_rdata", resp_rdata, e.rdata);
                checkOutput("misalign_exc", {31'b0, misalign_exc}, {31'b0, e.exc});
            end
        end
    end

    task automatic applyStimulus(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRdata,
                                 input logic expExc);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL ready_timeout: got req_ready=%b, expected 1", req_ready);
        end
        sbq.push_back('{rdata: expRdata, exc: expExc});
        req_valid  = 1'b1;
        req_store  = store;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acceptCyc = cyc;
    endtask

    task automatic waitResp(input string name, input int expLat);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (resp_valid === 1'b1) seen = 1;
        end
        if (!seen) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL %s_timeout: got no resp_valid, expected one within 20 cycles", name);
        end else begin
            checkOutput({name, "_latency"}, 32'(cyc - acceptCyc + 1), 32'(expLat));
            @(negedge clk);
            checkOutput({name, "_pulse"}, {31'b0, resp_valid}, 32'h0);
            checkOutput({name, "_ready"}, {31'b0, req_ready}, 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        checkOutput("rst_dm_w_en", {28'b0, dm_w_en}, 32'h0);
        checkOutput("rst_dm_address", {16'b0, dm_address}, 32'h0);
        checkOutput("rst_dm_write_data", dm_write_data, 32'h0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_misalign_exc", {31'b0, misalign_exc}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{1'b1, 3'b010, 32'h0010, 32'hDEADBEEF, 32'h0, 2});
        vecs.push_back('{1'b0, 3'b010, 32'h0010, 32'h0, 32'hDEADBEEF, 2});
        vecs.push_back('{1'b1, 3'b010, 32'h0020, 32'h80FF7F01, 32'h0, 2});
        vecs.push_back('{1'b0, 3'b000, 32'h0021, 32'h0, 32'h0000007F, 2});
        vecs.push_back('{1'b0, 3'b000, 32'h0023, 32'h0, 32'hFFFFFF80, 2});
        vecs.push_back('{1'b0, 3'b100, 32'h0023, 32'h0, 32'h00000080, 2});
        vecs.push_back('{1'b0, 3'b001, 32'h0022, 32'h0, 32'hFFFF80FF, 2});
        vecs.push_back('{1'b0, 3'b101, 32'h0022, 32'h0, 32'h000080FF, 2});
        vecs.push_back('{1'b0, 3'b000, 32'h0020, 32'h0, 32'h00000001, 2});
        vecs.push_back('{1'b0, 3'b001, 32'h0020, 32'h0, 32'h00007F01, 2});
        vecs.push_back('{1'b0, 3'b101, 32'h0012, 32'h0, 32'h0000DEAD, 2});
        vecs.push_back('{1'b0, 3'b001, 32'h0012, 32'h0, 32'hFFFFDEAD, 2});
        vecs.push_back('{1'b0, 3'b000, 32'h0013, 32'h0, 32'hFFFFFFDE, 2});
        vecs.push_back('{1'b0, 3'b010, 32'hABCD0010, 32'h0, 32'hDEADBEEF, 2});
        vecs.push_back('{1'b1, 3'b010, 32'h0030, 32'h12345678, 32'h0, 2});
        vecs.push_back('{1'b1, 3'b010, 32'h0034, 32'h00000000, 32'h0, 2});
        vecs.push_back('{1'b1, 3'b001, 32'h0036, 32'h0000BEEF, 32'h0, 2});
        vecs.push_back('{1'b0, 3'b010, 32'h0034, 32'h0, 32'hBEEF0000, 2});
        vecs.push_back('{1'b1, 3'b100, 32'h0010, 32'h00000000, 32'h0, 2});
        vecs.push_back('{1'b1, 3'b011, 32'h0010, 32'h00000000, 32'h0, 2});
        vecs.push_back('{1'b1, 3'b110, 32'h0010, 32'h00000000, 32'h0, 2});
        vecs.push_back('{1'b0, 3'b010, 32'h0010, 32'h0, 32'hDEADBEEF, 2});
        vecs.push_back('{1'b1, 3'b010, 32'h0040, 32'h00000000, 32'h0, 2});
        vecs.push_back('{1'b1, 3'b010, 32'h0044, 32'h00000000, 32'h0, 2});
        vecs.push_back('{1'b1, 3'b010, 32'h0000FFFC, 32'hAABBCCDD, 32'h0, 2});
        vecs.push_back('{1'b1, 3'b010, 32'h00000000, 32'h11223344, 32'h0, 2});
        vecs.push_back('{1'b1, 3'b010, 32'h0050, 32'h01020304, 32'h0, 2});

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].store, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].expRdata, 1'b0);
            waitResp($sformatf("vec%0d", i), vecs[i].expLat);
        end

        // Single-byte store lands on lane 2 only.
        applyStimulus(1'b1, 3'b000, 32'h0032, 32'h000000AA, 32'h0, 1'b0);
        checkOutput("sb_addr", {16'b0, dm_address}, 32'h0030);
        checkOutput("sb_w_en", {28'b0, dm_w_en}, 32'h4);
        checkOutput("sb_wdata", dm_write_data, 32'h00AA0000);
        waitResp("sb", 2);
        applyStimulus(1'b0, 3'b010, 32'h0030, 32'h0, 32'h12AA5678, 1'b0);
        waitResp("sb_readback", 2);

`ifndef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b1, 3'b010, 32'h0043, 32'h11223344, 32'h0, 1'b0);
        checkOutput("split_acc0_addr", {16'b0, dm_address}, 32'h0040);
        checkOutput("split_acc0_w_en", {28'b0, dm_w_en}, 32'h8);
        checkOutput("split_acc0_wdata", dm_write_data, 32'h44000000);
        @(posedge clk);
        #1;
        checkOutput("split_acc1_addr", {16'b0, dm_address}, 32'h0044);
        checkOutput("split_acc1_w_en", {28'b0, dm_w_en}, 32'h7);
        checkOutput("split_acc1_wdata", dm_write_data, 32'h00112233);
        waitResp("split_sw", 3);
        checkOutput("split_mem_lo", mem[32'h40 >> 2], 32'h44000000);
        checkOutput("split_mem_hi", mem[32'h44 >> 2], 32'h00112233);
        applyStimulus(1'b0, 3'b010, 32'h0043, 32'h0, 32'h11223344, 1'b0);
        waitResp("split_lw", 3);
        applyStimulus(1'b0, 3'b001, 32'h0043, 32'h0, 32'h00003344, 1'b0);
        waitResp("split_lh", 3);

        applyStimulus(1'b0, 3'b010, 32'h0000FFFE, 32'h0, 32'h3344AABB, 1'b0);
        checkOutput("wrap_acc0_addr", {16'b0, dm_address}, 32'hFFFC);
        @(posedge clk);
        #1;
        checkOutput("wrap_acc1_addr", {16'b0, dm_address}, 32'h0000);
        checkOutput("wrap_acc1_w_en", {28'b0, dm_w_en}, 32'h0);
        waitResp("wrap_lw", 3);
`else
        applyStimulus(1'b0, 3'b001, 32'h0051, 32'h0, 32'h0, 1'b1);
        checkOutput("trap_lh_resp", {31'b0, resp_valid}, 32'h1);
        checkOutput("trap_lh_w_en", {28'b0, dm_w_en}, 32'h0);
        waitResp("trap_lh", 1);
        applyStimulus(1'b1, 3'b010, 32'h0052, 32'hFFFFFFFF, 32'h0, 1'b1);
        checkOutput("trap_sw_w_en", {28'b0, dm_w_en}, 32'h0);
        waitResp("trap_sw", 1);
        applyStimulus(1'b0, 3'b010, 32'h0050, 32'h0, 32'h01020304, 1'b0);
        waitResp("trap_readback", 2);
`endif

        // Reset during ACC0 returns to IDLE at once and produces no response.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h0060; req_wdata = 32'h00000055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("midrst_acc0_w_en", {28'b0, dm_w_en}, 32'hF);
        checkOutput("midrst_acc0_ready", {31'b0, req_ready}, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("midrst_w_en", {28'b0, dm_w_en}, 32'h0);
        checkOutput("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(1'b0, 3'b010, 32'h0010, 32'h0, 32'hDEADBEEF, 1'b0);
        waitResp("post_rst_lw", 2);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sbq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
